sap_datapath: RTL and testbench
===============================

# sap_datapath

Bus-based 8-bit datapath executed by the microcoded instruction controller. Holds program counter, memory address register, 16×8 RAM, instruction register, A/B registers, add/subtract ALU and output register, all sharing one 8-bit bus. Each cycle it consumes the controller's 15-bit control word and feeds the current opcode back to the controller. A load port lets the testbench or a front panel write the program into RAM while execution is frozen.

## Interface
- No parameters; widths are fixed: bus 8, address 4, control word 15.
- clk  in  1  system clock; all state updates on posedge. The controller updates the control word on negedge, so it is stable at each posedge.
- rst  in  1  asynchronous, active-high reset.
- ctrl_wrd  in  15  control bits, MSB to LSB: [14]HLT [13]MI [12]RI [11]RO [10]IO [9]II [8]AI [7]AO [6]SO [5]SU [4]BI [3]OI [2]CE [1]CO [0]J.
- load_mode  in  1  1 = freeze execution and accept program writes.
- prog_we  in  1  RAM write strobe; honoured only while load_mode=1.
- prog_addr  in  4  RAM write address.
- prog_data  in  8  RAM write data.
- opcode  out  4  IR[7:4], fed to the controller.
- run_en  out  1  controller enable, equal to ~halted & ~load_mode.
- out_data  out  8  output register.
- out_strobe  out  1  one-cycle pulse on the cycle after OI loads out_data.
- carry_flag, zero_flag  out  1 each  ALU flags.
- bus_conflict  out  1  sticky error flag; set when more than one bus driver is asserted.
- halted  out  1  set by HLT.

## Operation
- Bus drivers are ORed to a source select with fixed priority RO > IO > AO > SO > CO.
  - RO: RAM[MAR].
  - IO: {4'h0, IR[3:0]}.
  - AO: A.
  - SO: ALU result.
  - CO: {4'h0, PC}.
  - No driver: bus = 8'h00.
- Loads at posedge when the bit is set, all sampling the same cycle's bus:
  - MI: MAR ← bus[3:0].
  - RI: RAM[MAR] ← bus.
  - II: IR ← bus.
  - AI: A ← bus.
  - BI: B ← bus.
  - OI: out_data ← bus.
  - J: PC ← bus[3:0].
- ALU is combinational: SU=0 gives A+B, SU=1 gives A−B (A + ~B + 1). Result is truncated to 8 bits.
- Flags update only when AI and SO are both set in the same cycle:
  - carry_flag = bit 8 of the 9-bit sum (for subtract, 1 means no borrow).
  - zero_flag = (result == 0).
- CE: PC ← PC+1 mod 16, so 15 wraps to 0. If J and CE are both set, J wins.
- HLT sets halted. While halted, every register, RAM and flag load is suppressed. Only rst or load_mode clears halted.
- load_mode=1:
  - ctrl_wrd is ignored.
  - PC, MAR, IR, A, B and the flags are cleared to 0, and halted is cleared.
  - prog_we writes prog_data to RAM[prog_addr].
  - out_data is retained.
  - Execution resumes from PC=0 on the first cycle after load_mode falls.
- bus_conflict is set if two or more of RO/IO/AO/SO/CO are asserted in a non-frozen cycle. It is cleared only by rst.

## Timing
- Reset values:
  - All registers 0, opcode 0, out_data 8'h00.
  - out_strobe, flags, halted and bus_conflict all 0.
  - run_en = 1 unless load_mode is high.
  - RAM contents are not reset.
- rst mid-instruction aborts immediately. The controller is responsible for its own step counter.
- Register load latency is 1 cycle: the value is visible after the posedge at which the control bit was sampled.
- RAM read is combinational from MAR. A write followed by a read of the same address in the next cycle returns the new data.
- out_strobe is high exactly one cycle per OI cycle, including consecutive OI cycles.
- run_en falls combinationally with halted/load_mode, i.e. in the cycle after the HLT posedge.

## Structure
- Package sap_pkg holds:
  - Control-bit index constants (HLT_B=14 … J_B=0).
  - Opcode constants: LDA=1, ADD=2, SUB=3, JMP=4, OUT=14, HLT=15.
  - Width constants.
- One sub-module, sap_ram16x8: synchronous write, asynchronous read, with a second write port muxed in for load_mode.
- Remaining logic (bus mux, registers, ALU, flags) is flat in sap_datapath.

## Test plan
- Reset → all outputs at reset values, bus_conflict=0, run_en=1.
- Load RAM[0]=8'h1E, RAM[14]=8'h07; apply ctrl words CO|MI, then RO|II|CE → IR=8'h1E, opcode=1, PC=1.
- A=8'hF0, B=8'h20, SO|AI with SU=0 → A=8'h10, carry=1, zero=0. A=8'h05, B=8'h05, SO|SU|AI → A=0, zero=1, carry=1.
- PC=15, CE → PC=0. J with bus=8'h03 together with CE → PC=3.
- AO|OI twice in consecutive cycles → out_data=A and out_strobe high for 2 cycles. AO|CO together → bus=A, bus_conflict=1 and stays set.
- HLT, then AI|CO → A unchanged, halted=1, run_en=0. Raise load_mode, write RAM, drop load_mode → halted=0, PC=0, RAM holds the new data.

Source files
------------

// File: rtl/sap_pkg.sv
// sap_pkg: shared widths, control-word bit positions and opcodes for the SAP datapath
package sap_pkg;
  localparam int BUS_W  = 8;
  localparam int ADDR_W = 4;
  localparam int CW_W   = 15;
  localparam int OP_W   = 4;
  localparam int HLT_B = 14;
  localparam int MI_B  = 13;
  localparam int RI_B  = 12;
  localparam int RO_B  = 11;
  localparam int IO_B  = 10;
  localparam int II_B  = 9;
  localparam int AI_B  = 8;
  localparam int AO_B  = 7;
  localparam int SO_B  = 6;
  localparam int SU_B  = 5;
  localparam int BI_B  = 4;
  localparam int OI_B  = 3;
  localparam int CE_B  = 2;
  localparam int CO_B  = 1;
  localparam int J_B   = 0;
  localparam logic [OP_W-1:0] OP_LDA = 4'd1;
  localparam logic [OP_W-1:0] OP_ADD = 4'd2;
  localparam logic [OP_W-1:0] OP_SUB = 4'd3;
  localparam logic [OP_W-1:0] OP_JMP = 4'd4;
  localparam logic [OP_W-1:0] OP_OUT = 4'd14;
  localparam logic [OP_W-1:0] OP_HLT = 4'd15;
endpackage

// File: rtl/sap_ram16x8.sv
// sap_ram16x8: 16x8 RAM, async read, sync write with a program-load port taking over in load mode
module sap_ram16x8
  import sap_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [BUS_W-1:0]  wdata,
  output logic [BUS_W-1:0]  q,
  input  logic              load_mode,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [BUS_W-1:0]  prog_data
);
  logic [BUS_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] wa;
  logic [BUS_W-1:0] wd;
  logic wen;
  assign wen = load_mode ? prog_we : we;
  assign wa = load_mode ? prog_addr : addr;
  assign wd = load_mode ? prog_data : wdata;
  assign q = mem[addr];
  // write port: front-panel data while loading, bus data otherwise
  always_ff @(posedge clk)
    if (wen) mem[wa] <= wd;
endmodule

// File: rtl/sap_datapath.sv
// sap_datapath: shared-bus 8-bit SAP datapath driven by a 15-bit control word
module sap_datapath
  import sap_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [CW_W-1:0]   ctrl_wrd,
  input  logic              load_mode,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [BUS_W-1:0]  prog_data,
  output logic [OP_W-1:0]   opcode,
  output logic              run_en,
  output logic [BUS_W-1:0]  out_data,
  output logic              out_strobe,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic              bus_conflict,
  output logic              halted
);
  logic [ADDR_W-1:0] pc, mar;
  logic [BUS_W-1:0] ir, a, b, bus, ram_q;
  logic [BUS_W:0] sum;
  logic [CW_W-1:0] c;
  logic conflict;
  assign c = (load_mode | halted) ? '0 : ctrl_wrd;
  assign sum = {1'b0, a} + {1'b0, c[SU_B] ? ~b : b} + {{BUS_W{1'b0}}, c[SU_B]};
  assign conflict = $countones({c[RO_B], c[IO_B], c[AO_B], c[SO_B], c[CO_B]}) > 1;
  assign opcode = ir[7:4];
  assign run_en = ~halted & ~load_mode;
  // fixed-priority bus source select
  always_comb
    bus = c[RO_B] ? ram_q :
          c[IO_B] ? {4'h0, ir[3:0]} :
          c[AO_B] ? a :
          c[SO_B] ? sum[BUS_W-1:0] :
          c[CO_B] ? {4'h0, pc} : '0;
  sap_ram16x8 u_ram (
    .clk       (clk),
    .we        (c[RI_B]),
    .addr      (mar),
    .wdata     (bus),
    .q         (ram_q),
    .load_mode (load_mode),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data)
  );
  // register file: load mode clears execution state, otherwise each set bit samples the bus
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc <= '0;
      mar <= '0;
      ir <= '0;
      a <= '0;
      b <= '0;
      out_data <= '0;
      out_strobe <= 1'b0;
      carry_flag <= 1'b0;
      zero_flag <= 1'b0;
      halted <= 1'b0;
      bus_conflict <= 1'b0;
    end else if (load_mode) begin
      pc <= '0;
      mar <= '0;
      ir <= '0;
      a <= '0;
      b <= '0;
      out_strobe <= 1'b0;
      carry_flag <= 1'b0;
      zero_flag <= 1'b0;
      halted <= 1'b0;
    end else begin
      if (c[MI_B]) mar <= bus[ADDR_W-1:0];
      if (c[II_B]) ir <= bus;
      if (c[AI_B]) a <= bus;
      if (c[BI_B]) b <= bus;
      if (c[OI_B]) out_data <= bus;
      pc <= c[J_B] ? bus[ADDR_W-1:0] : c[CE_B] ? pc + 1'b1 : pc;
      if (c[AI_B] && c[SO_B]) begin
        carry_flag <= sum[BUS_W];
        zero_flag <= (sum[BUS_W-1:0] == '0);
      end
      out_strobe <= c[OI_B];
      if (c[HLT_B]) halted <= 1'b1;
      if (conflict) bus_conflict <= 1'b1;
    end
endmodule

// File: tb/tb_sap_datapath.sv
// tb_sap_datapath: directed and randomized checks of sap_datapath against a behavioural model
module tb_sap_datapath;
  localparam logic [14:0] HLT = 15'h4000, MI = 15'h2000, RI = 15'h1000, RO = 15'h0800,
                          IO = 15'h0400, II = 15'h0200, AI = 15'h0100, AO = 15'h0080,
                          SO = 15'h0040, SU = 15'h0020, BI = 15'h0010, OI = 15'h0008,
                          CE = 15'h0004, CO = 15'h0002, J = 15'h0001;
  logic clk = 0, rst = 1, load_mode = 0, prog_we = 0;
  logic [14:0] ctrl_wrd = '0;
  logic [3:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic [3:0] opcode;
  logic run_en, out_strobe, carry_flag, zero_flag, bus_conflict, halted;
  logic [7:0] out_data;
  int nvec = 0, nfail = 0;
  logic [7:0] m_mem [16];
  logic [7:0] m_ir, m_a, m_b, m_out;
  logic [3:0] m_pc, m_mar;
  logic m_strobe, m_c, m_z, m_halt, m_conf;

  sap_datapath dut (
    .clk(clk), .rst(rst), .ctrl_wrd(ctrl_wrd), .load_mode(load_mode), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data), .opcode(opcode), .run_en(run_en),
    .out_data(out_data), .out_strobe(out_strobe), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .bus_conflict(bus_conflict), .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic bit on(input logic [14:0] cw, input logic [14:0] m);
    return (cw & m) != 0;
  endfunction

  task automatic m_clear();
    m_pc = 0; m_mar = 0; m_ir = 0; m_a = 0; m_b = 0;
    m_c = 0; m_z = 0; m_halt = 0; m_strobe = 0;
  endtask

  task automatic cyc(input logic [14:0] cw);
    logic [7:0] bus;
    logic [8:0] full;
    int nd;
    ctrl_wrd = cw;
    if (load_mode) begin
      m_clear();
      if (prog_we) m_mem[prog_addr] = prog_data;
    end else if (m_halt) begin
      m_strobe = 0;
    end else begin
      full = on(cw, SU) ? 9'(m_a) + 9'd256 - 9'(m_b) : 9'(m_a) + 9'(m_b);
      nd = int'(on(cw, RO)) + int'(on(cw, IO)) + int'(on(cw, AO)) + int'(on(cw, SO)) + int'(on(cw, CO));
      if (on(cw, RO)) bus = m_mem[m_mar];
      else if (on(cw, IO)) bus = {4'h0, m_ir[3:0]};
      else if (on(cw, AO)) bus = m_a;
      else if (on(cw, SO)) bus = full[7:0];
      else if (on(cw, CO)) bus = {4'h0, m_pc};
      else bus = 8'h00;
      if (nd >= 2) m_conf = 1;
      if (on(cw, RI)) m_mem[m_mar] = bus;
      if (on(cw, MI)) m_mar = bus[3:0];
      if (on(cw, II)) m_ir = bus;
      if (on(cw, AI)) m_a = bus;
      if (on(cw, BI)) m_b = bus;
      if (on(cw, OI)) m_out = bus;
      if (on(cw, J)) m_pc = bus[3:0];
      else if (on(cw, CE)) m_pc = 4'((int'(m_pc) + 1) % 16);
      if (on(cw, AI) && on(cw, SO)) begin
        m_c = full[8];
        m_z = full[7:0] == 0;
      end
      m_strobe = on(cw, OI);
      if (on(cw, HLT)) m_halt = 1;
    end
    @(posedge clk);
    #1;
    ctrl_wrd = '0;
  endtask

  task automatic prog(input logic [3:0] ad, input logic [7:0] d);
    load_mode = 1; prog_we = 1; prog_addr = ad; prog_data = d;
    cyc('0);
    prog_we = 0;
  endtask

  task automatic goto_pc(input logic [3:0] k);
    while (m_pc != k) cyc(CE);
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    rst = 1;
    m_clear(); m_out = 0; m_conf = 0;
    @(posedge clk); #1;
    nvec++;
    if ({opcode, out_data, out_strobe, carry_flag, zero_flag, bus_conflict, halted, run_en} !== {4'h0, 8'h00, 5'b0, 1'b1}) begin
      nfail++;
      $display("FAIL reset: got op=%h out=%h stb=%b c=%b z=%b conf=%b hlt=%b run=%b, want all 0 and run_en=1",
               opcode, out_data, out_strobe, carry_flag, zero_flag, bus_conflict, halted, run_en);
    end
    rst = 0;
  endtask

  task automatic test_fetch();
    prog(4'd0, 8'h1E); prog(4'd14, 8'h07);
    load_mode = 0;
    cyc(CO | MI);
    cyc(RO | II | CE);
    nvec++;
    if (opcode !== 4'd1) begin nfail++; $display("FAIL fetch opcode: got %h want 1", opcode); end
    cyc(IO | OI);
    nvec++;
    if ({out_data, out_strobe} !== {8'h0E, 1'b1}) begin nfail++; $display("FAIL fetch ir_low: got %h/%b want 0e/1", out_data, out_strobe); end
    cyc(CO | OI);
    nvec++;
    if (out_data !== 8'h01) begin nfail++; $display("FAIL fetch pc: got %h want 01", out_data); end
    cyc(IO | MI);
    cyc(RO | OI);
    nvec++;
    if (out_data !== 8'h07) begin nfail++; $display("FAIL fetch operand: got %h want 07", out_data); end
  endtask

  task automatic test_alu();
    prog(4'd1, 8'hF0); prog(4'd2, 8'h20); prog(4'd3, 8'h05);
    load_mode = 0;
    goto_pc(4'd1); cyc(CO | MI); cyc(RO | AI);
    goto_pc(4'd2); cyc(CO | MI); cyc(RO | BI);
    cyc(SO | AI);
    nvec++;
    if ({carry_flag, zero_flag} !== 2'b10) begin nfail++; $display("FAIL add flags: got c=%b z=%b want c=1 z=0", carry_flag, zero_flag); end
    cyc(AO | OI);
    nvec++;
    if (out_data !== 8'h10) begin nfail++; $display("FAIL add result: got %h want 10", out_data); end
    goto_pc(4'd3); cyc(CO | MI); cyc(RO | AI); cyc(RO | BI);
    cyc(SO | SU | AI);
    nvec++;
    if ({carry_flag, zero_flag} !== 2'b11) begin nfail++; $display("FAIL sub flags: got c=%b z=%b want c=1 z=1", carry_flag, zero_flag); end
    cyc(AO | OI);
    nvec++;
    if (out_data !== 8'h00) begin nfail++; $display("FAIL sub result: got %h want 00", out_data); end
    cyc(SO | SU | AI);
    cyc(AO | OI);
    nvec++;
    if ({out_data, carry_flag, zero_flag} !== {8'hFB, 2'b00}) begin
      nfail++; $display("FAIL borrow: got %h c=%b z=%b want fb c=0 z=0", out_data, carry_flag, zero_flag);
    end
  endtask

  task automatic test_pc();
    prog(4'd5, 8'h03);
    load_mode = 0;
    goto_pc(4'd15);
    cyc(CO | OI);
    nvec++;
    if (out_data !== 8'h0F) begin nfail++; $display("FAIL pc15: got %h want 0f", out_data); end
    cyc(CE);
    cyc(CO | OI);
    nvec++;
    if (out_data !== 8'h00) begin nfail++; $display("FAIL pc wrap: got %h want 00", out_data); end
    goto_pc(4'd5); cyc(CO | MI);
    cyc(RO | J | CE);
    cyc(CO | OI);
    nvec++;
    if (out_data !== 8'h03) begin nfail++; $display("FAIL jump over ce: got %h want 03", out_data); end
  endtask

  task automatic test_back_to_back();
    cyc(RO | AI);
    cyc(AO | OI);
    nvec++;
    if ({out_data, out_strobe} !== {8'h03, 1'b1}) begin nfail++; $display("FAIL strobe1: got %h/%b want 03/1", out_data, out_strobe); end
    cyc(AO | OI);
    nvec++;
    if (out_strobe !== 1'b1) begin nfail++; $display("FAIL strobe2: got %b want 1", out_strobe); end
    cyc('0);
    nvec++;
    if ({out_strobe, bus_conflict} !== 2'b00) begin nfail++; $display("FAIL strobe end: got stb=%b conf=%b want 0/0", out_strobe, bus_conflict); end
    cyc(AO | CO | OI);
    nvec++;
    if ({out_data, bus_conflict} !== {8'h03, 1'b1}) begin nfail++; $display("FAIL conflict: got %h/%b want 03/1", out_data, bus_conflict); end
    cyc('0); cyc('0);
    nvec++;
    if (bus_conflict !== 1'b1) begin nfail++; $display("FAIL conflict sticky: got %b want 1", bus_conflict); end
  endtask

  task automatic test_halt();
    cyc(HLT);
    nvec++;
    if ({halted, run_en} !== 2'b10) begin nfail++; $display("FAIL halt: got hlt=%b run=%b want 1/0", halted, run_en); end
    cyc(AI | CO);
    cyc(CO | OI | CE);
    nvec++;
    if ({out_data, out_strobe, halted} !== {8'h03, 1'b0, 1'b1}) begin
      nfail++; $display("FAIL halt freeze: got %h stb=%b hlt=%b want 03/0/1", out_data, out_strobe, halted);
    end
    prog(4'd7, 8'h5A);
    nvec++;
    if (run_en !== 1'b0) begin nfail++; $display("FAIL load run_en: got %b want 0", run_en); end
    load_mode = 0;
    #1;
    nvec++;
    if ({halted, run_en, out_data} !== {2'b01, 8'h03}) begin
      nfail++; $display("FAIL load exit: got hlt=%b run=%b out=%h want 0/1/03", halted, run_en, out_data);
    end
    cyc(CO | OI);
    nvec++;
    if (out_data !== 8'h00) begin nfail++; $display("FAIL resume pc: got %h want 00", out_data); end
    goto_pc(4'd7); cyc(CO | MI); cyc(RO | OI);
    nvec++;
    if (out_data !== 8'h5A) begin nfail++; $display("FAIL loaded ram: got %h want 5a", out_data); end
  endtask

  task automatic test_random();
    logic [14:0] drv [6];
    logic [14:0] cw;
    logic [17:0] got, exp;
    drv = '{15'h0, RO, IO, AO, SO, CO};
    test_reset();
    for (int i = 0; i < 16; i++) prog(4'(i), 8'($urandom));
    load_mode = 0;
    for (int n = 0; n < 600; n++) begin
      if (m_halt && $urandom_range(0, 3) == 0) begin
        prog(4'($urandom), 8'($urandom));
        load_mode = 0;
      end
      cw = 15'($urandom) & (MI | RI | II | AI | SU | BI | OI | CE | J);
      cw |= drv[$urandom_range(0, 5)];
      if ($urandom_range(0, 39) == 0) cw |= drv[$urandom_range(1, 5)];
      if ($urandom_range(0, 49) == 0) cw |= HLT;
      cyc(cw);
      got = {opcode, out_data, out_strobe, carry_flag, zero_flag, bus_conflict, halted, run_en};
      exp = {m_ir[7:4], m_out, m_strobe, m_c, m_z, m_conf, m_halt, ~m_halt & ~load_mode};
      nvec++;
      if (got !== exp) begin
        nfail++;
        $display("FAIL random step %0d cw=%h: got {op,out,stb,c,z,conf,hlt,run}=%h want %h", n, cw, got, exp);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_mem[i] = 0;
    test_reset();
    test_fetch();
    test_alu();
    test_pc();
    test_back_to_back();
    test_halt();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
